device_uart_responder: RTL and testbench



---
 rtl/device_uart_responder.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_device_uart_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/device_uart_responder.sv
// Device-bus responder for the shared 0xFC00-0xFFFF window: status/TX/RX UART
// registers, a free-running 32-bit cycle counter and requesting-core-id readback.
module device_uart_responder #(
    parameter int NUM_CORES     = 16,
    parameter int CLKS_PER_BIT  = 868,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [9:0]                   device_addr,
    input  logic                         device_write_en,
    input  logic                         device_read_en,
    input  logic [15:0]                  device_data_out,
    input  logic [$clog2(NUM_CORES)-1:0] device_core_id,
    output logic [15:0]                  device_data_in,
    output logic                         uart_tx,
    input  logic                         uart_rx
);
    localparam int AW = $clog2(TX_FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(TX_FIFO_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic sel_status, sel_tx, sel_rx, sel_lo;
    assign sel_status = (device_addr == 10'h000);
    assign sel_tx     = (device_addr == 10'h001);
    assign sel_rx     = (device_addr == 10'h002);
    assign sel_lo     = (device_addr == 10'h003);

    logic unused_hi;
    assign unused_hi = ^device_data_out[15:8];

    // TX FIFO; full/empty come from the registered count, so a push while full
    // is dropped even if the transmitter pops in the same cycle.
    logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          tx_full, tx_empty, tx_push_req, tx_push, tx_pop;

    assign tx_full     = (fifo_cnt == FIFO_FULL);
    assign tx_empty    = (fifo_cnt == '0);
    assign tx_push_req = device_write_en && sel_tx;
    assign tx_push     = tx_push_req && !tx_full;

    always_ff @(posedge clk) begin
        if (tx_push) fifo_mem[wr_ptr] <= device_data_out[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (tx_push) wr_ptr <= wr_ptr + AW'(1);
            if (tx_pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_cnt <= fifo_cnt + {{AW{1'b0}}, tx_push} - {{AW{1'b0}}, tx_pop};
        end
    end

    // TX FSM: the stop bit chains straight into the next start bit when data is waiting.
    tx_state_t     tx_state, tx_state_n;
    logic [BW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_idx, tx_idx_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          tx_line_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            uart_tx  <= tx_line_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        tx_line_n  = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = fifo_mem[rd_ptr];
                    tx_cnt_n   = '0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_idx_n   = '0;
                    tx_state_n = TX_DATA;
                end else begin
                    tx_cnt_n = tx_cnt + BW'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    if (tx_idx == 3'd7) tx_state_n = TX_STOP;
                    else                tx_idx_n   = tx_idx + 3'd1;
                end else begin
                    tx_cnt_n = tx_cnt + BW'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = fifo_mem[rd_ptr];
                        tx_state_n = TX_START;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + BW'(1);
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        case (tx_state_n)
            TX_START: tx_line_n = 1'b0;
            TX_DATA:  tx_line_n = tx_shift_n[0];
            default:  tx_line_n = 1'b1;
        endcase
    end

    // RX: two-flop synchronizer plus one more stage for falling-edge detection.
    logic rx_s1, rx_s2, rx_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    rx_state_t     rx_state, rx_state_n;
    logic [BW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_idx, rx_idx_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_load, rx_ferr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_load    = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s2) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                // Half a bit in: a high line here was a glitch, not a start bit.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_idx_n   = '0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + BW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    if (rx_idx == 3'd7) rx_state_n = RX_STOP;
                    else                rx_idx_n   = rx_idx + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt + BW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                    if (rx_s2) rx_load = 1'b1;
                    else       rx_ferr = 1'b1;
                end else begin
                    rx_cnt_n = rx_cnt + BW'(1);
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // Register file, sticky flags and registered read port.
    logic [31:0] cycle_cnt;
    logic [15:0] hi_snap, rd_data;
    logic [7:0]  rx_byte;
    logic        rx_valid, tx_ovf, rx_ferr_st, rx_ovr_st;
    logic        wr_status, rd_rx;

    assign wr_status = device_write_en && sel_status;
    assign rd_rx     = device_read_en && sel_rx;

    always_comb begin
        rd_data = '0;
        case (device_addr)
            10'h000: rd_data = {10'd0, rx_ovr_st, rx_ferr_st, tx_ovf, rx_valid, tx_empty, tx_full};
            10'h002: rd_data = {8'h00, rx_byte};
            10'h003: rd_data = cycle_cnt[15:0];
            10'h004: rd_data = hi_snap;
            10'h005: rd_data = 16'(device_core_id);
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt      <= '0;
            hi_snap        <= '0;
            rx_byte        <= '0;
            rx_valid       <= 1'b0;
            tx_ovf         <= 1'b0;
            rx_ferr_st     <= 1'b0;
            rx_ovr_st      <= 1'b0;
            device_data_in <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            // Clears first so a same-cycle event still sets its flag.
            if (wr_status && device_data_out[3]) tx_ovf     <= 1'b0;
            if (wr_status && device_data_out[4]) rx_ferr_st <= 1'b0;
            if (wr_status && device_data_out[5]) rx_ovr_st  <= 1'b0;
            if (tx_push_req && tx_full) tx_ovf <= 1'b1;
            if (rx_ferr) rx_ferr_st <= 1'b1;
            if (rx_load) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
                if (rx_valid) rx_ovr_st <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
            if (device_read_en) begin
                device_data_in <= rd_data;
                if (sel_lo) hi_snap <= cycle_cnt[31:16];
            end
        end
    end

endmodule

// File: tb/tb_device_uart_responder.sv
// Scoreboard bench for device_uart_responder: register reads and serial TX frames
// are queued as expectations by the stimulus and checked by independent monitors.
module tb_device_uart_responder;
    localparam int NUM_CORES = 16;
    localparam int CPB       = 4;
    localparam int DEPTH     = 8;
    localparam int FW        = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  device_addr = '0;
    logic        device_write_en = 1'b0;
    logic        device_read_en = 1'b0;
    logic [15:0] device_data_out = '0;
    logic [3:0]  device_core_id = '0;
    logic [15:0] device_data_in;
    logic        uart_tx;
    logic        uart_rx = 1'b1;

    device_uart_responder #(
        .NUM_CORES(NUM_CORES),
        .CLKS_PER_BIT(CPB),
        .TX_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .device_addr(device_addr),
        .device_write_en(device_write_en),
        .device_read_en(device_read_en),
        .device_data_out(device_data_out),
        .device_core_id(device_core_id),
        .device_data_in(device_data_in),
        .uart_tx(uart_tx),
        .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    string       name_q[$];
    logic [7:0]  tx_exp_q[$];

    // Reference cycle counter: zero while reset is sampled, +1 each clock otherwise.
    logic [31:0] tb_cnt = '0;
    always @(posedge clk) tb_cnt <= reset ? 32'd0 : tb_cnt + 32'd1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] tx_wave(input logic [7:0] b);
        logic [FW-1:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[CPB*(i+1) +: CPB] = {CPB{b[i]}};
        w[FW-1 -: CPB] = {CPB{1'b1}};
        return w;
    endfunction

    // Read-data monitor: data is valid the cycle after a sampled read strobe.
    logic rd_seen = 1'b0;
    always @(posedge clk) rd_seen <= device_read_en && !reset;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_unexpected: got 0x%0h with no expected read", device_data_in);
            end else begin
                check(name_q.pop_front(), 64'(device_data_in), 64'(exp_q.pop_front()));
            end
        end
    end

    // TX monitor: captures every cycle of a frame from its first low sample.
    logic [FW-1:0] tx_got;
    logic          tx_abort;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && uart_tx === 1'b0) begin
                tx_got    = '0;
                tx_abort  = 1'b0;
                tx_got[0] = uart_tx;
                for (int c = 1; c < FW && !tx_abort; c++) begin
                    @(negedge clk);
                    if (reset) tx_abort = 1'b1;
                    else       tx_got[c] = uart_tx;
                end
                if (!tx_abort) begin
                    if (tx_exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL tx_unexpected: got frame 0x%0h with no expected byte", tx_got);
                    end else begin
                        check("tx_frame", 64'(tx_got), 64'(tx_wave(tx_exp_q.pop_front())));
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [9:0] addr, input logic [15:0] data);
        device_addr     = addr;
        device_data_out = data;
        device_write_en = 1'b1;
        @(negedge clk);
        device_write_en = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] addr, input logic [15:0] exp, input string name);
        device_addr    = addr;
        device_read_en = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        device_read_en = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_data_in", 64'(device_data_in), 64'h0);
        check("reset_uart_tx", 64'(uart_tx), 64'h1);
        reset = 1'b0;
        do_read(10'h000, 16'h0002, "reset_status");

        // Single byte; empty flag drops while queued, returns once popped.
        tx_exp_q.push_back(8'h55);
        do_write(10'h001, 16'h0055);
        do_read(10'h000, 16'h0000, "status_tx_queued");
        do_read(10'h000, 16'h0002, "status_tx_popped");
        idle(50);

        device_core_id = 4'd5;
        do_read(10'h005, 16'h0005, "core_id_5");
        device_core_id = 4'd15;
        do_read(10'h005, 16'h000F, "core_id_15");
        device_core_id = 4'd0;
        do_read(10'h3FF, 16'h0000, "unmapped_read");
        do_write(10'h3FF, 16'hFFFF);
        do_read(10'h001, 16'h0000, "tx_data_read");
        do_read(10'h000, 16'h0002, "status_after_unmapped_write");
        do_read(10'h003, tb_cnt[15:0], "cycle_lo_live");

        // Overflow: transmitter busy, then nine writes into an eight-entry FIFO.
        tx_exp_q.push_back(8'h10);
        do_write(10'h001, 16'h0010);
        idle(3);
        for (int i = 1; i <= 9; i++) begin
            if (i <= DEPTH) tx_exp_q.push_back(8'(16 + i));
            do_write(10'h001, 16'(16 + i));
        end
        do_read(10'h000, 16'h0009, "status_overflow");
        do_write(10'h000, 16'h0008);
        do_read(10'h000, 16'h0001, "status_overflow_cleared");
        idle(9 * FW + 20);
        do_read(10'h000, 16'h0002, "status_tx_drained");
        check("tx_frames_pending", 64'(tx_exp_q.size()), 64'h0);

        // Receive path.
        send_rx(8'hA5, 1'b1);
        idle(4);
        do_read(10'h000, 16'h0006, "status_rx_valid");
        do_read(10'h002, 16'h00A5, "rx_data_a5");
        do_read(10'h000, 16'h0002, "status_rx_consumed");

        send_rx(8'h3C, 1'b0);
        idle(4);
        do_read(10'h000, 16'h0012, "status_frame_err");
        do_write(10'h000, 16'h0010);
        do_read(10'h000, 16'h0002, "status_frame_err_cleared");

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        idle(4);
        do_read(10'h000, 16'h0026, "status_overrun");
        do_read(10'h002, 16'h0022, "rx_data_second");
        do_read(10'h000, 16'h0022, "status_overrun_sticky");
        do_write(10'h000, 16'h0020);
        do_read(10'h000, 16'h0002, "status_overrun_cleared");

        // Snapshot across the 16-bit rollover of the cycle counter.
        while (tb_cnt < 32'h0000_FFFF) @(negedge clk);
        do_read(10'h003, 16'hFFFF, "cycle_lo_ffff");
        do_read(10'h004, 16'h0000, "cycle_hi_snapshot");
        do_read(10'h003, tb_cnt[15:0], "cycle_lo_after_roll");
        do_read(10'h004, 16'h0001, "cycle_hi_after_roll");

        // Reset in the middle of data bit 3 of a frame.
        device_core_id = 4'd5;
        do_read(10'h005, 16'h0005, "core_id_before_reset");
        device_core_id = 4'd0;
        do_write(10'h001, 16'h00C3);
        idle(18);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_frame_uart_tx", 64'(uart_tx), 64'h1);
        check("reset_mid_frame_data_in", 64'(device_data_in), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        do_read(10'h000, 16'h0002, "status_after_reset");
        idle(2 * FW);

        check("reads_pending", 64'(exp_q.size()), 64'h0);
        check("tx_frames_left", 64'(tx_exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
